// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared constants and types for the ID/EX pipeline stage.
//   XLEN        datapath width
//   REG_ADDR_W  register address width (x0..x31)
//   ZERO_REG    architectural zero register address
//   CTRL_W      width of the opaque decoded control bundle
//   CTRL_*      bit positions of fields inside the control bundle (EX decodes these)
//   NOP_CTRL    control value of a bubble / killed slot (all zero)
//   ex_regs_t   contents of the ID/EX register
//   sat_inc     saturating 32-bit increment used by the statistics counters
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CTRL_W     = 16;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    // Control bundle layout. This stage never looks inside the bundle; the
    // offsets live here so decode and execute agree on one definition.
    localparam int CTRL_ALU_OP_LSB = 0;
    localparam int CTRL_ALU_OP_W   = 4;
    localparam int CTRL_SRC_B_IMM  = 4;
    localparam int CTRL_MEM_WE     = 5;
    localparam int CTRL_MEM_RE     = 6;
    localparam int CTRL_REG_WE     = 7;
    localparam int CTRL_BRANCH     = 8;
    localparam int CTRL_JUMP       = 9;

    localparam logic [CTRL_W-1:0] NOP_CTRL = '0;

    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       op1;
        logic [XLEN-1:0]       op2;
        logic [XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [CTRL_W-1:0]     ctrl;
        logic                  is_load;
    } ex_regs_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
        return (en && (value != 32'hFFFF_FFFF)) ? value + 32'd1 : value;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_stage_if
// Bundle of every non-clock signal of the ID/EX stage.
//   master : decode/writeback/execute side (drives id_*, wb_*, flush, ex_hold,
//            observes ex_*, stall_id and the statistics counters)
//   slave  : the id_ex_stage itself
// -----------------------------------------------------------------------------
interface id_ex_stage_if;
    import pipe_pkg::*;

    // Decode side
    logic                  id_valid;
    logic [XLEN-1:0]       id_pc;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [XLEN-1:0]       id_rd1;
    logic [XLEN-1:0]       id_rd2;
    logic [XLEN-1:0]       id_imm;
    logic [CTRL_W-1:0]     id_ctrl;
    logic                  id_is_load;

    // Writeback port (same signals that write the register file)
    logic                  wb_we;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_wd;

    // Pipeline control
    logic                  flush;
    logic                  ex_hold;

    // Execute side
    logic                  ex_valid;
    logic [XLEN-1:0]       ex_pc;
    logic [XLEN-1:0]       ex_op1;
    logic [XLEN-1:0]       ex_op2;
    logic [XLEN-1:0]       ex_imm;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [CTRL_W-1:0]     ex_ctrl;
    logic                  ex_is_load;
    logic                  stall_id;

    // Statistics
    logic [31:0]           stat_stalls;
    logic [31:0]           stat_bubbles;
    logic [31:0]           stat_flushes;

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
               id_rd1, id_rd2, id_imm, id_ctrl, id_is_load,
               wb_we, wb_rd, wb_wd, flush, ex_hold,
        input  ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rs1, ex_rs2, ex_rd,
               ex_ctrl, ex_is_load, stall_id,
               stat_stalls, stat_bubbles, stat_flushes
    );

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
               id_rd1, id_rd2, id_imm, id_ctrl, id_is_load,
               wb_we, wb_rd, wb_wd, flush, ex_hold,
        output ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rs1, ex_rs2, ex_rd,
               ex_ctrl, ex_is_load, stall_id,
               stat_stalls, stat_bubbles, stat_flushes
    );

endinterface

// File: rtl/wb_bypass.sv
// -----------------------------------------------------------------------------
// wb_bypass
// Combinational operand select for one source register. The register file
// only commits a WB write at the clock edge, so a write in the same cycle as
// the ID read must be forwarded here.
//   rs       source register address
//   rf_data  register-file read data for rs
//   wb_we    writeback enable
//   wb_rd    writeback destination
//   wb_wd    writeback data
//   op       operand to capture into EX
// -----------------------------------------------------------------------------
module wb_bypass
    import pipe_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [XLEN-1:0]       rf_data,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_wd,
    output logic [XLEN-1:0]       op
);

    always_comb begin
        op = rf_data;
        // x0 reads as zero whatever the register file or WB bus claims
        if (rs == ZERO_REG) begin
            op = '0;
        end else if (wb_we && (wb_rd == rs)) begin
            op = wb_wd;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with same-cycle WB bypass, load-use bubble
// insertion, flush and downstream hold.
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    id_ex_stage_if.slave: id_* decode inputs, wb_* writeback port,
//          flush / ex_hold controls, ex_* registered outputs, stall_id
//          (combinational IF/ID hold request) and three statistics counters
// Build option: define ID_EX_STATS_EN to implement the saturating
// stat_stalls / stat_bubbles / stat_flushes counters; otherwise they read 0.
// Priority of the per-cycle update: flush > ex_hold > load-use bubble > capture.
// -----------------------------------------------------------------------------
module id_ex_stage
    import pipe_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    id_ex_stage_if.slave bus
);

    ex_regs_t        ex_q;
    ex_regs_t        ex_d;
    logic [XLEN-1:0] op1_n;
    logic [XLEN-1:0] op2_n;
    logic            lu;

    // Operand bypass, one instance per source register
    wb_bypass u_bypass_rs1 (
        .rs      (bus.id_rs1),
        .rf_data (bus.id_rd1),
        .wb_we   (bus.wb_we),
        .wb_rd   (bus.wb_rd),
        .wb_wd   (bus.wb_wd),
        .op      (op1_n)
    );

    wb_bypass u_bypass_rs2 (
        .rs      (bus.id_rs2),
        .rf_data (bus.id_rd2),
        .wb_we   (bus.wb_we),
        .wb_rd   (bus.wb_rd),
        .wb_wd   (bus.wb_wd),
        .op      (op2_n)
    );

    // Load in EX whose result an ID operand needs: the data only exists after
    // the memory stage, so ID must wait one cycle.
    always_comb begin
        lu = ex_q.valid && ex_q.is_load && (ex_q.rd != ZERO_REG) && bus.id_valid &&
             ((bus.id_uses_rs1 && (bus.id_rs1 == ex_q.rd)) ||
              (bus.id_uses_rs2 && (bus.id_rs2 == ex_q.rd)));
    end

    // A flush discards ID anyway, so it never needs to be held.
    assign bus.stall_id = (lu || bus.ex_hold) && !bus.flush;

    always_comb begin
        ex_d = ex_q;
        if (bus.flush || (!bus.ex_hold && lu)) begin
            // Kill or bubble: only the fields that give the slot architectural
            // effect are cleared; data fields are left as they were.
            ex_d.valid   = 1'b0;
            ex_d.ctrl    = NOP_CTRL;
            ex_d.is_load = 1'b0;
            ex_d.rd      = ZERO_REG;
        end else if (!bus.ex_hold) begin
            ex_d.valid   = bus.id_valid;
            ex_d.pc      = bus.id_pc;
            ex_d.op1     = op1_n;
            ex_d.op2     = op2_n;
            ex_d.imm     = bus.id_imm;
            ex_d.rs1     = bus.id_rs1;
            ex_d.rs2     = bus.id_rs2;
            ex_d.rd      = bus.id_valid ? bus.id_rd      : ZERO_REG;
            ex_d.ctrl    = bus.id_valid ? bus.id_ctrl    : NOP_CTRL;
            ex_d.is_load = bus.id_valid ? bus.id_is_load : 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign bus.ex_valid   = ex_q.valid;
    assign bus.ex_pc      = ex_q.pc;
    assign bus.ex_op1     = ex_q.op1;
    assign bus.ex_op2     = ex_q.op2;
    assign bus.ex_imm     = ex_q.imm;
    assign bus.ex_rs1     = ex_q.rs1;
    assign bus.ex_rs2     = ex_q.rs2;
    assign bus.ex_rd      = ex_q.rd;
    assign bus.ex_ctrl    = ex_q.ctrl;
    assign bus.ex_is_load = ex_q.is_load;

`ifdef ID_EX_STATS_EN
    logic [31:0] stat_stalls_q;
    logic [31:0] stat_stalls_d;
    logic [31:0] stat_bubbles_q;
    logic [31:0] stat_bubbles_d;
    logic [31:0] stat_flushes_q;
    logic [31:0] stat_flushes_d;

    always_comb begin
        stat_stalls_d  = sat_inc(stat_stalls_q, bus.stall_id);
        // A bubble is only inserted when lu actually wins the priority order
        stat_bubbles_d = sat_inc(stat_bubbles_q, lu && !bus.flush && !bus.ex_hold);
        // Flushes of an already empty pipe are not interesting
        stat_flushes_d = sat_inc(stat_flushes_q, bus.flush && (ex_q.valid || bus.id_valid));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_stalls_q  <= '0;
            stat_bubbles_q <= '0;
            stat_flushes_q <= '0;
        end else begin
            stat_stalls_q  <= stat_stalls_d;
            stat_bubbles_q <= stat_bubbles_d;
            stat_flushes_q <= stat_flushes_d;
        end
    end

    assign bus.stat_stalls  = stat_stalls_q;
    assign bus.stat_bubbles = stat_bubbles_q;
    assign bus.stat_flushes = stat_flushes_q;
`else
    assign bus.stat_stalls  = '0;
    assign bus.stat_bubbles = '0;
    assign bus.stat_flushes = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Self-checking bench for id_ex_stage: directed scenarios followed by a
// randomized run checked against a cycle-level reference model.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;
    import pipe_pkg::*;

    localparam int BW = 1 + 4*XLEN + 3*REG_ADDR_W + CTRL_W + 1;

`ifdef ID_EX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    id_ex_stage_if bus();

    id_ex_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    logic                  m_valid, m_load;
    logic [XLEN-1:0]       m_pc, m_op1, m_op2, m_imm;
    logic [REG_ADDR_W-1:0] m_rs1, m_rs2, m_rd;
    logic [CTRL_W-1:0]     m_ctrl;
    logic [31:0]           m_stalls, m_bubbles, m_flushes;

    function automatic logic [BW-1:0] obs_bundle();
        return {bus.ex_valid, bus.ex_pc, bus.ex_op1, bus.ex_op2, bus.ex_imm,
                bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_ctrl, bus.ex_is_load};
    endfunction

    function automatic logic [BW-1:0] model_bundle();
        return {m_valid, m_pc, m_op1, m_op2, m_imm, m_rs1, m_rs2, m_rd, m_ctrl, m_load};
    endfunction

    // Architectural value of a register as seen by an instruction in ID
    function automatic logic [XLEN-1:0] reg_value(input logic [4:0] a, input logic [XLEN-1:0] rf);
        if (a == 5'd0) return '0;
        if (bus.wb_we && bus.wb_rd == a) return bus.wb_wd;
        return rf;
    endfunction

    function automatic bool_t_dummy();
        return 0;
    endfunction

    function automatic logic model_load_use();
        return m_valid && m_load && m_rd != 0 && bus.id_valid &&
               ((bus.id_uses_rs1 && bus.id_rs1 == m_rd) || (bus.id_uses_rs2 && bus.id_rs2 == m_rd));
    endfunction

    function automatic logic model_stall();
        return (model_load_use() || bus.ex_hold) && !bus.flush;
    endfunction

    function automatic logic [31:0] inc_sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    task automatic model_reset();
        {m_valid, m_pc, m_op1, m_op2, m_imm, m_rs1, m_rs2, m_rd, m_ctrl, m_load} = '0;
        m_stalls = 0; m_bubbles = 0; m_flushes = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_next();
        logic lu;
        lu = model_load_use();
        if (STATS) begin
            if (model_stall()) m_stalls = inc_sat(m_stalls);
            if (lu && !bus.flush && !bus.ex_hold) m_bubbles = inc_sat(m_bubbles);
            if (bus.flush && (m_valid || bus.id_valid)) m_flushes = inc_sat(m_flushes);
        end
        if (bus.flush || (lu && !bus.ex_hold)) begin
            m_valid = 0; m_ctrl = 0; m_load = 0; m_rd = 0;
        end else if (!bus.ex_hold) begin
            m_valid = bus.id_valid;
            m_pc    = bus.id_pc;
            m_op1   = reg_value(bus.id_rs1, bus.id_rd1);
            m_op2   = reg_value(bus.id_rs2, bus.id_rd2);
            m_imm   = bus.id_imm;
            m_rs1   = bus.id_rs1;
            m_rs2   = bus.id_rs2;
            m_rd    = bus.id_valid ? bus.id_rd : 5'd0;
            m_ctrl  = bus.id_valid ? bus.id_ctrl : '0;
            m_load  = bus.id_valid ? bus.id_is_load : 1'b0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        bus.id_valid = 0; bus.id_pc = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
        bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0; bus.id_rd1 = 0; bus.id_rd2 = 0;
        bus.id_imm = 0; bus.id_ctrl = 0; bus.id_is_load = 0;
        bus.wb_we = 0; bus.wb_rd = 0; bus.wb_wd = 0; bus.flush = 0; bus.ex_hold = 0;
    endtask

    task automatic instr(input logic [31:0] pc, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic ld, input logic [15:0] ctrl);
        bus.id_valid = 1; bus.id_pc = pc; bus.id_rs1 = rs1; bus.id_uses_rs1 = u1;
        bus.id_rs2 = rs2; bus.id_uses_rs2 = u2; bus.id_rd = rd; bus.id_is_load = ld;
        bus.id_ctrl = ctrl; bus.id_rd1 = pc ^ 32'hA0; bus.id_rd2 = pc ^ 32'hB0;
        bus.id_imm = pc + 32'h10;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        idle_inputs();
        model_reset();
        #2 reset = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] exp_stat;
        @(negedge clk);
        reset = 1;
        instr(32'h80, 5'd3, 1, 5'd4, 1, 5'd5, 1, 16'hFFFF);
        bus.ex_hold = 0;
        #1;
        vectors++;
        if (obs_bundle() !== '0) begin
            miscompares++;
            $display("FAIL reset_ex_outputs got=%h exp=0", obs_bundle());
        end
        exp_stat = 0;
        vectors++;
        if ({bus.stat_stalls, bus.stat_bubbles, bus.stat_flushes} !== {3{exp_stat}}) begin
            miscompares++;
            $display("FAIL reset_counters got=%h/%h/%h exp=0", bus.stat_stalls, bus.stat_bubbles, bus.stat_flushes);
        end
        vectors++;
        if (bus.stall_id !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_stall_nohold got=%b exp=0", bus.stall_id);
        end
        bus.ex_hold = 1;
        #1;
        vectors++;
        if (bus.stall_id !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_stall_hold got=%b exp=1", bus.stall_id);
        end
        $display("txn reset: ex_valid=%b stall_id=%b", bus.ex_valid, bus.stall_id);
        #2 reset = 0;
        idle_inputs();
    endtask

    task automatic test_bypass();
        do_reset();
        instr(32'h100, 5'd5, 1, 5'd6, 1, 5'd7, 0, 16'h0081);
        bus.id_rd1 = 32'h0;
        bus.wb_we = 1; bus.wb_rd = 5'd5; bus.wb_wd = 32'h1234;
        step();
        vectors++;
        if (bus.ex_op1 !== 32'h1234 || bus.ex_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bypass_rs1 got op1=%h valid=%b exp op1=00001234 valid=1", bus.ex_op1, bus.ex_valid);
        end
        vectors++;
        if (bus.ex_op2 !== (32'h100 ^ 32'hB0)) begin
            miscompares++;
            $display("FAIL bypass_rs2_nomatch got=%h exp=%h", bus.ex_op2, 32'h100 ^ 32'hB0);
        end
        $display("txn bypass: ex_op1=%h ex_op2=%h", bus.ex_op1, bus.ex_op2);
        // x0 guard: WB targeting x0 and a garbage register-file value both ignored
        instr(32'h104, 5'd8, 1, 5'd0, 1, 5'd9, 0, 16'h0002);
        bus.id_rd2 = 32'h55;
        bus.wb_we = 1; bus.wb_rd = 5'd0; bus.wb_wd = 32'hFFFF;
        step();
        vectors++;
        if (bus.ex_op2 !== 32'h0) begin
            miscompares++;
            $display("FAIL x0_guard got=%h exp=00000000", bus.ex_op2);
        end
        $display("txn x0_guard: ex_op2=%h", bus.ex_op2);
    endtask

    task automatic test_load_use();
        logic [31:0] exp_b;
        do_reset();
        instr(32'h40, 5'd0, 0, 5'd0, 0, 5'd9, 1, 16'h00F1);
        step();
        instr(32'h44, 5'd3, 1, 5'd9, 1, 5'd4, 0, 16'h0102);
        #1;
        vectors++;
        if (bus.stall_id !== 1'b1) begin
            miscompares++;
            $display("FAIL lu_stall got=%b exp=1", bus.stall_id);
        end
        step();
        vectors++;
        if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 16'h0 || bus.ex_rd !== 5'd0) begin
            miscompares++;
            $display("FAIL lu_bubble got valid=%b ctrl=%h rd=%0d exp valid=0 ctrl=0000 rd=0",
                     bus.ex_valid, bus.ex_ctrl, bus.ex_rd);
        end
        vectors++;
        if (bus.stall_id !== 1'b0) begin
            miscompares++;
            $display("FAIL lu_single_stall got=%b exp=0", bus.stall_id);
        end
        step();
        vectors++;
        if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h44 || bus.ex_rd !== 5'd4 || bus.ex_ctrl !== 16'h0102) begin
            miscompares++;
            $display("FAIL lu_recapture got valid=%b pc=%h rd=%0d ctrl=%h exp valid=1 pc=00000044 rd=4 ctrl=0102",
                     bus.ex_valid, bus.ex_pc, bus.ex_rd, bus.ex_ctrl);
        end
        exp_b = STATS ? 32'd1 : 32'd0;
        vectors++;
        if (bus.stat_bubbles !== exp_b) begin
            miscompares++;
            $display("FAIL lu_stat_bubbles got=%0d exp=%0d", bus.stat_bubbles, exp_b);
        end
        $display("txn load_use: ex_pc=%h stat_bubbles=%0d", bus.ex_pc, bus.stat_bubbles);
        // Control: the loaded register is named but not read
        do_reset();
        instr(32'h40, 5'd0, 0, 5'd0, 0, 5'd9, 1, 16'h00F1);
        step();
        instr(32'h48, 5'd3, 1, 5'd9, 0, 5'd4, 0, 16'h0103);
        #1;
        vectors++;
        if (bus.stall_id !== 1'b0) begin
            miscompares++;
            $display("FAIL lu_unused_rs2 got=%b exp=0", bus.stall_id);
        end
        step();
        vectors++;
        if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h48) begin
            miscompares++;
            $display("FAIL lu_unused_capture got valid=%b pc=%h exp valid=1 pc=00000048", bus.ex_valid, bus.ex_pc);
        end
        $display("txn load_use_ctrl: stall_id=%b ex_pc=%h", bus.stall_id, bus.ex_pc);
    endtask

    task automatic test_flush_hold();
        do_reset();
        instr(32'h200, 5'd1, 1, 5'd2, 1, 5'd3, 0, 16'h0F0F);
        step();
        instr(32'h204, 5'd1, 1, 5'd2, 1, 5'd4, 0, 16'h0F0E);
        bus.flush = 1; bus.ex_hold = 1;
        #1;
        vectors++;
        if (bus.stall_id !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_hold_stall got=%b exp=0", bus.stall_id);
        end
        step();
        vectors++;
        if (bus.ex_valid !== 1'b0 || bus.ex_rd !== 5'd0 || bus.ex_ctrl !== 16'h0) begin
            miscompares++;
            $display("FAIL flush_beats_hold got valid=%b rd=%0d ctrl=%h exp valid=0 rd=0 ctrl=0000",
                     bus.ex_valid, bus.ex_rd, bus.ex_ctrl);
        end
        $display("txn flush_hold: ex_valid=%b", bus.ex_valid);
    endtask

    task automatic test_hold();
        logic [BW-1:0] snap;
        logic [31:0]   exp_s;
        do_reset();
        instr(32'h300, 5'd1, 1, 5'd2, 1, 5'd7, 0, 16'h5A5A);
        step();
        snap = {1'b1, 32'h300, 32'h300 ^ 32'hA0, 32'h300 ^ 32'hB0, 32'h310,
                5'd1, 5'd2, 5'd7, 16'h5A5A, 1'b0};
        for (int c = 0; c < 3; c++) begin
            instr($urandom, 5'($urandom), 1, 5'($urandom), 1, 5'($urandom), 1'($urandom), 16'($urandom));
            bus.wb_we = 1; bus.wb_rd = 5'd1; bus.wb_wd = $urandom;
            bus.ex_hold = 1;
            #1;
            vectors++;
            if (bus.stall_id !== 1'b1) begin
                miscompares++;
                $display("FAIL hold_stall[%0d] got=%b exp=1", c, bus.stall_id);
            end
            step();
            vectors++;
            if (obs_bundle() !== snap) begin
                miscompares++;
                $display("FAIL hold_regs[%0d] got=%h exp=%h", c, obs_bundle(), snap);
            end
            $display("txn hold[%0d]: stall_id=%b ex_pc=%h", c, bus.stall_id, bus.ex_pc);
        end
        exp_s = STATS ? 32'd3 : 32'd0;
        vectors++;
        if (bus.stat_stalls !== exp_s) begin
            miscompares++;
            $display("FAIL hold_stat_stalls got=%0d exp=%0d", bus.stat_stalls, exp_s);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        instr(32'h40, 5'd0, 0, 5'd0, 0, 5'd9, 1, 16'h00F1);
        step();
        instr(32'h44, 5'd9, 1, 5'd0, 0, 5'd4, 0, 16'h0102);
        step();                 // bubble now in EX, ex_pc still 0x40
        #2 reset = 1;
        #1;
        vectors++;
        if (bus.ex_valid !== 1'b0 || bus.ex_pc !== 32'h0 || bus.ex_op1 !== 32'h0) begin
            miscompares++;
            $display("FAIL async_reset_regs got valid=%b pc=%h op1=%h exp all 0", bus.ex_valid, bus.ex_pc, bus.ex_op1);
        end
        vectors++;
        if ({bus.stat_stalls, bus.stat_bubbles, bus.stat_flushes} !== 96'h0) begin
            miscompares++;
            $display("FAIL async_reset_counters got=%h/%h/%h exp=0", bus.stat_stalls, bus.stat_bubbles, bus.stat_flushes);
        end
        vectors++;
        if (bus.stall_id !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset_stall got=%b exp=0", bus.stall_id);
        end
        $display("txn async_reset: ex_valid=%b ex_pc=%h", bus.ex_valid, bus.ex_pc);
        #2 reset = 0;
    endtask

    task automatic test_random();
        logic exp_stall;
        do_reset();
        for (int c = 0; c < 250; c++) begin
            bus.id_valid    = ($urandom_range(0, 9) < 8);
            bus.id_pc       = $urandom;
            bus.id_rs1      = 5'($urandom_range(0, 7));
            bus.id_rs2      = 5'($urandom_range(0, 7));
            bus.id_rd       = 5'($urandom_range(0, 7));
            bus.id_uses_rs1 = 1'($urandom);
            bus.id_uses_rs2 = 1'($urandom);
            bus.id_rd1      = $urandom;
            bus.id_rd2      = $urandom;
            bus.id_imm      = $urandom;
            bus.id_ctrl     = 16'($urandom);
            bus.id_is_load  = ($urandom_range(0, 9) < 4);
            bus.wb_we       = 1'($urandom);
            bus.wb_rd       = 5'($urandom_range(0, 7));
            bus.wb_wd       = $urandom;
            bus.flush       = ($urandom_range(0, 9) == 0);
            bus.ex_hold     = ($urandom_range(0, 9) < 2);
            #1;
            exp_stall = model_stall();
            vectors++;
            if (bus.stall_id !== exp_stall) begin
                miscompares++;
                $display("FAIL rand_stall[%0d] got=%b exp=%b", c, bus.stall_id, exp_stall);
            end
            model_next();
            step();
            vectors++;
            if (obs_bundle() !== model_bundle()) begin
                miscompares++;
                $display("FAIL rand_regs[%0d] got=%h exp=%h", c, obs_bundle(), model_bundle());
            end
            vectors++;
            if (bus.stat_stalls !== m_stalls || bus.stat_bubbles !== m_bubbles || bus.stat_flushes !== m_flushes) begin
                miscompares++;
                $display("FAIL rand_stats[%0d] got=%0d/%0d/%0d exp=%0d/%0d/%0d", c,
                         bus.stat_stalls, bus.stat_bubbles, bus.stat_flushes, m_stalls, m_bubbles, m_flushes);
            end
            $display("txn rand[%0d]: stall=%b ex_valid=%b ex_rd=%0d ex_op1=%h", c,
                     exp_stall, bus.ex_valid, bus.ex_rd, bus.ex_op1);
        end
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        model_reset();
        test_reset();
        test_bypass();
        test_load_use();
        test_flush_hold();
        test_hold();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register between the register-file read (decode) and execute.
- Register file reads are combinational and writes land on posedge clk, so a same-cycle WB write is invisible to the ID read. This block bypasses WB data into the captured operands.
- Detects load-use hazards and inserts one bubble. Honours flush (taken branch/jump) and downstream hold.

Parameters:
- XLEN, 32, datapath width.
- CTRL_W, 16, width of opaque decoded control bundle passed to EX.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  XLEN  instruction PC.
- id_rs1, id_rs2, id_rd  in  5 each  register addresses.
- id_uses_rs1, id_uses_rs2  in  1 each  operand actually read.
- id_rd1, id_rd2  in  XLEN each  register-file read data.
- id_imm  in  XLEN  decoded immediate.
- id_ctrl  in  CTRL_W  control bundle.
- id_is_load  in  1  instruction is a load.
- wb_we  in  1  WB write enable (same signal driving the register file).
- wb_rd  in  5  WB destination address.
- wb_wd  in  XLEN  WB write data.
- flush  in  1  kill ID/EX contents (from EX branch resolution).
- ex_hold  in  1  EX not accepting (multi-cycle op).
- ex_valid  out  1  EX holds a real instruction.
- ex_pc, ex_op1, ex_op2, ex_imm  out  XLEN each.
- ex_rs1, ex_rs2, ex_rd  out  5 each.
- ex_ctrl  out  CTRL_W.
- ex_is_load  out  1.
- stall_id  out  1  combinational: IF/ID and PC must hold this cycle.
- stat_stalls, stat_bubbles, stat_flushes  out  32 each  counters (see Optional Feature).

Behaviour:
- Reset, asynchronous: every ex_* output is 0. ex_valid=0, counters=0. stall_id then depends only on ex_hold.
- Bypass, combinational on the ID side:
  - op1_n = wb_wd if wb_we && wb_rd==id_rs1 && id_rs1!=0, else id_rd1.
  - op2_n is the same with rs2/rd2.
  - A read of x0 always yields 0, regardless of id_rd1/id_rd2.
- Load-use hazard, lu = ex_valid && ex_is_load && ex_rd!=0 && id_valid && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
- stall_id = (lu || ex_hold) && !flush.
- Per-cycle update, priority descending:
  - 1. flush: ex_valid<=0, ex_ctrl<=0, ex_is_load<=0, ex_rd<=0. Other fields are don't-care, held.
  - 2. ex_hold: all registers hold.
  - 3. lu: bubble. ex_valid<=0, ex_ctrl<=0, ex_is_load<=0, ex_rd<=0. ID is held by stall_id, so the instruction re-presents next cycle and captures normally.
  - 4. otherwise capture: ex_valid<=id_valid, ex_op1<=op1_n, ex_op2<=op2_n, all other fields from id_*.
  - If id_valid=0 on capture, ctrl/is_load/rd are zeroed.
- Latency: one cycle ID to EX. A load-use costs exactly one bubble.
- During ex_hold, stale operands in EX are not refreshed here; EX-side forwarding owns that.
- Reset mid-hold or mid-bubble: outputs clear immediately. There is no residual stall state.

Optional Feature:
- Macro: ID_EX_STATS_EN.
- Defined: three saturating 32-bit counters.
  - stat_stalls increments on each cycle stall_id=1.
  - stat_bubbles increments per lu bubble inserted.
  - stat_flushes increments per flush cycle with ex_valid or id_valid high.
  - All counters saturate at 0xFFFFFFFF.
- Undefined: ports still exist, tied to 0, and no counter flops are synthesised.

Decomposition:
- Shared package pipe_pkg: XLEN, REG_ADDR_W=5, ZERO_REG=5'd0, CTRL_W, ctrl field bit offsets, NOP control constant (all zero).
- Sub-module wb_bypass: combinational 2:1 operand select including the x0 rule, instantiated twice. Everything else stays in id_ex_stage.

Test Plan:
- Same-cycle WB bypass: wb_we=1, wb_rd=5, wb_wd=0x1234, id_rs1=5, id_rd1=0 -> next cycle ex_op1=0x1234, ex_valid=1.
- x0 guard: wb_we=1, wb_rd=0, wb_wd=0xFFFF, id_rs2=0, id_rd2=0x55 -> ex_op2=0.
- Load-use, with EX holding a load (ex_rd=9) and ID id_rs2=9, id_uses_rs2=1:
  - stall_id=1 for one cycle, then ex_valid=0 and ex_ctrl=0.
  - Following cycle: instruction captured, stat_bubbles=1 with ID_EX_STATS_EN defined.
  - Control case, id_uses_rs2=0: no stall.
- Flush beats hold, flush=1 and ex_hold=1 together -> ex_valid=0 next cycle, stall_id=0.
- Hold: ex_hold=1 for 3 cycles with changing ID inputs -> ex_* unchanged, stall_id=1 all 3 cycles, stat_stalls=3.
- Asynchronous reset asserted mid-cycle during a bubble -> ex_valid=0 and counters 0 immediately, with no clk edge needed.
